bounded_counter_register: RTL and testbench
===========================================

// Module: bounded_counter_register
// PURPOSE
//  Parametrised successor to the plain ctrl-driven register.
//  Holds a WIDTH-bit value confined to [MIN_VAL, MAX_VAL].
//  Supports clear, load, and step-sized increment/decrement with wrap or saturate at the bounds.
//  Raises limit flags and a one-cycle rollover pulse.
//  Used as the countdown/arming timer and digit counters in the detonator datapath.
// PARAMETERS
//  WIDTH    8    data width in bits
//  MIN_VAL  0    lower bound; reset/clear value
//  MAX_VAL  255  upper bound; legal only if MIN_VAL <= MAX_VAL <= 2^WIDTH-1
//  WRAP     1    1: overflow reloads the opposite bound; 0: saturate at the bound
// PORTS
//  clk          in   1      clock; all state changes on its rising edge
//  reset        in   1      synchronous, active-high reset
//  ctrl         in   3      operation select (encoding below)
//  data_input   in   WIDTH  load value for LD
//  step         in   WIDTH  increment/decrement amount for INC/DEC
//  data_output  out  WIDTH  current register value
//  at_min       out  1      data_output == MIN_VAL
//  at_max       out  1      data_output == MAX_VAL
//  rollover     out  1      registered one-cycle pulse: last INC/DEC crossed a bound
// BEHAVIOUR
//  - Reset (sampled at posedge clk, highest priority over ctrl):
//    data = MIN_VAL, rollover = 0, at_min = 1, at_max = (MIN_VAL == MAX_VAL).
//  - ctrl encoding:
//    000 HOLD, 001 CLR, 010 LD, 011 INC, 100 DEC, 101 SHL, 110 SHR, 111 HOLD.
//  - Latency: result visible on data_output one cycle after ctrl is sampled.
//    at_min/at_max decode data_reg directly (no extra cycle). rollover is registered alongside data.
//  - HOLD: data unchanged.
//  - CLR: data = MIN_VAL.
//  - LD: data = clamp(data_input, MIN_VAL, MAX_VAL). Clamping never asserts rollover.
//  - INC: sum = data + step, computed in WIDTH+1 bits (no silent truncation).
//    - sum <= MAX_VAL: data = sum.
//    - sum > MAX_VAL: data = MIN_VAL if WRAP=1, else MAX_VAL; rollover = 1.
//  - DEC: diff = data - step, computed in WIDTH+1 bits signed.
//    - diff >= MIN_VAL: data = diff.
//    - diff < MIN_VAL: data = MAX_VAL if WRAP=1, else MIN_VAL; rollover = 1.
//  - step = 0 on INC/DEC: data unchanged, rollover = 0.
//  - INC at MAX_VAL or DEC at MIN_VAL with step >= 1 is an over/underflow.
//    In saturate mode data stays put and rollover still pulses.
//  - rollover = 0 on every cycle not meeting the INC/DEC bound condition, including HOLD/CLR/LD/shift.
//  - SHL/SHR: see CONFIGURATION.
//  - Reset mid-sequence: any pending rollover is dropped. No state survives reset.
// CONFIGURATION
//  Macro BCR_SHIFT_EN:
//  - Defined:
//    SHL: data = clamp(data << 1, MIN_VAL, MAX_VAL), shift computed in WIDTH+1 bits.
//    SHR: data = clamp(data >> 1, MIN_VAL, MAX_VAL).
//    Neither asserts rollover.
//  - Undefined: 101 and 110 behave as HOLD. No shift logic is synthesised.
// TESTING
//  Bench configuration: WIDTH=8, MIN_VAL=10, MAX_VAL=20, WRAP=1 unless stated.
//  1. reset=1 for 1 clk with ctrl=INC, step=1 -> data_output=10, at_min=1, at_max=0, rollover=0.
//  2. LD 25 -> data_output=20, at_max=1, rollover=0.
//     Then LD 5 -> 10. Then LD 15 -> 15.
//  3. data=18, INC step=3 -> 10, rollover=1 for exactly one cycle.
//     Repeat with WRAP=0 -> 20, rollover=1. Then INC step=1 -> 20, rollover=1 again.
//  4. data=12, DEC step=5 -> 20, rollover=1.
//     Then DEC step=0 -> 20, rollover=0. Then HOLD x3 -> 20, rollover=0.
//  5. BCR_SHIFT_EN defined: data=12, SHL -> 20 (24 clamped), then SHR -> 10.
//     Macro undefined: same stimulus -> data stays 12.
//  6. data=19, INC step=255 -> sum=274 in 9 bits, data=10, rollover=1.
//     Then reset asserted while ctrl=INC -> 10, rollover=0.

Source files
------------

// File: rtl/bounded_counter_register_if.sv
// Operation/result bundle for bounded_counter_register; master drives ctrl/load/step, slave returns value and flags.
interface bounded_counter_register_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] data_input;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] data_output;
  logic             at_min;
  logic             at_max;
  logic             rollover;

  modport master (
    output ctrl, data_input, step,
    input  data_output, at_min, at_max, rollover
  );

  modport slave (
    input  ctrl, data_input, step,
    output data_output, at_min, at_max, rollover
  );
endinterface

// File: rtl/bounded_counter_register.sv
// Bounded WIDTH-bit register: clear/load/step inc-dec with wrap or saturate, one-cycle result latency, no backpressure.
// Optional SHL/SHR ops are built only when BCR_SHIFT_EN is defined; otherwise those codes hold.
module bounded_counter_register #(
  parameter int WIDTH   = 8,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 255,
  parameter bit WRAP    = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  bounded_counter_register_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);

  localparam logic [2:0] OP_CLR = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
`ifdef BCR_SHIFT_EN
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
`endif

  logic [WIDTH-1:0]        data_reg;
  logic                    roll_reg;
  logic [WIDTH-1:0]        data_nxt;
  logic                    roll_nxt;
  logic [WIDTH:0]          sum;
  logic signed [WIDTH:0]   diff;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH:0] v);
    if (v < {1'b0, MIN_L})      return MIN_L;
    else if (v > {1'b0, MAX_L}) return MAX_L;
    else                        return v[WIDTH-1:0];
  endfunction

  // Extra bit on both paths keeps carry/borrow visible to the bound tests.
  assign sum  = {1'b0, data_reg} + {1'b0, bus.step};
  assign diff = $signed({1'b0, data_reg}) - $signed({1'b0, bus.step});

  always_comb begin
    data_nxt = data_reg;
    roll_nxt = 1'b0;
    case (bus.ctrl)
      OP_CLR: data_nxt = MIN_L;
      OP_LD:  data_nxt = clamp({1'b0, bus.data_input});
      OP_INC: begin
        if (sum > {1'b0, MAX_L}) begin
          data_nxt = WRAP ? MIN_L : MAX_L;
          roll_nxt = 1'b1;
        end else begin
          data_nxt = sum[WIDTH-1:0];
        end
      end
      OP_DEC: begin
        if (diff < $signed({1'b0, MIN_L})) begin
          data_nxt = WRAP ? MAX_L : MIN_L;
          roll_nxt = 1'b1;
        end else begin
          data_nxt = diff[WIDTH-1:0];
        end
      end
`ifdef BCR_SHIFT_EN
      OP_SHL: data_nxt = clamp({data_reg, 1'b0});
      OP_SHR: data_nxt = clamp({2'b00, data_reg[WIDTH-1:1]});
`endif
      default: data_nxt = data_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= MIN_L;
      roll_reg <= 1'b0;
    end else begin
      data_reg <= data_nxt;
      roll_reg <= roll_nxt;
    end
  end

  assign bus.data_output = data_reg;
  assign bus.at_min      = (data_reg == MIN_L);
  assign bus.at_max      = (data_reg == MAX_L);
  assign bus.rollover    = roll_reg;

endmodule

// File: tb/tb_bounded_counter_register.sv
// Drives a wrapping and a saturating instance (range 10..20) with directed and random ops against an integer model.
module tb_bounded_counter_register;

  localparam int LO = 10;
  localparam int HI = 20;

  logic clk = 1'b0;
  logic reset;

  bounded_counter_register_if #(.WIDTH(8)) wif ();
  bounded_counter_register_if #(.WIDTH(8)) sif ();

  bounded_counter_register #(.WIDTH(8), .MIN_VAL(LO), .MAX_VAL(HI), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .bus(wif.slave)
  );
  bounded_counter_register #(.WIDTH(8), .MIN_VAL(LO), .MAX_VAL(HI), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .bus(sif.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  // Model state: index 0 = wrapping instance, index 1 = saturating instance.
  int md[2];
  int mr[2];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < LO) return LO;
    if (v > HI) return HI;
    return v;
  endfunction

  task automatic model_op(input int i, input bit rst, input int c, input int din, input int stp);
    int v;
    bit wrap;
    wrap = (i == 0);
    mr[i] = 0;
    if (rst) begin
      md[i] = LO;
      return;
    end
    case (c)
      1: md[i] = LO;
      2: md[i] = clampi(din);
      3: begin
        v = md[i] + stp;
        if (v > HI) begin md[i] = wrap ? LO : HI; mr[i] = 1; end
        else md[i] = v;
      end
      4: begin
        v = md[i] - stp;
        if (v < LO) begin md[i] = wrap ? HI : LO; mr[i] = 1; end
        else md[i] = v;
      end
`ifdef BCR_SHIFT_EN
      5: md[i] = clampi(md[i] * 2);
      6: md[i] = clampi(md[i] / 2);
`endif
      default: ;
    endcase
  endtask

  task automatic apply(input bit rst, input int c, input int din, input int stp);
    reset = rst;
    wif.ctrl = 3'(c); wif.data_input = 8'(din); wif.step = 8'(stp);
    sif.ctrl = 3'(c); sif.data_input = 8'(din); sif.step = 8'(stp);
    @(posedge clk);
    model_op(0, rst, c, din, stp);
    model_op(1, rst, c, din, stp);
    #1;
    check_eq("w_data",   int'(wif.data_output), md[0]);
    check_eq("w_at_min", int'(wif.at_min),      int'(md[0] == LO));
    check_eq("w_at_max", int'(wif.at_max),      int'(md[0] == HI));
    check_eq("w_roll",   int'(wif.rollover),    mr[0]);
    check_eq("s_data",   int'(sif.data_output), md[1]);
    check_eq("s_at_min", int'(sif.at_min),      int'(md[1] == LO));
    check_eq("s_at_max", int'(sif.at_max),      int'(md[1] == HI));
    check_eq("s_roll",   int'(sif.rollover),    mr[1]);
  endtask

  initial begin
    int c, din, stp;
    bit rst;
    reset = 1'b0;
    wif.ctrl = 3'b000; wif.data_input = '0; wif.step = '0;
    sif.ctrl = 3'b000; sif.data_input = '0; sif.step = '0;
    md[0] = 0; md[1] = 0; mr[0] = 0; mr[1] = 0;
    @(negedge clk);

    // Reset beats a concurrent INC.
    apply(1'b1, 3, 0, 1);
    check_eq("rst_data", int'(wif.data_output), 10);
    check_eq("rst_min",  int'(wif.at_min), 1);
    check_eq("rst_max",  int'(wif.at_max), 0);
    check_eq("rst_roll", int'(wif.rollover), 0);

    apply(1'b0, 2, 25, 0);
    check_eq("ld25", int'(wif.data_output), 20);
    check_eq("ld25_max", int'(wif.at_max), 1);
    apply(1'b0, 2, 5, 0);
    check_eq("ld5", int'(wif.data_output), 10);
    apply(1'b0, 2, 15, 0);
    check_eq("ld15", int'(wif.data_output), 15);

    apply(1'b0, 2, 18, 0);
    apply(1'b0, 3, 0, 3);
    check_eq("inc_wrap", int'(wif.data_output), 10);
    check_eq("inc_wrap_roll", int'(wif.rollover), 1);
    check_eq("inc_sat", int'(sif.data_output), 20);
    check_eq("inc_sat_roll", int'(sif.rollover), 1);
    apply(1'b0, 0, 0, 0);
    check_eq("roll_pulse_end", int'(wif.rollover), 0);
    apply(1'b0, 2, 20, 0);
    apply(1'b0, 3, 0, 1);
    check_eq("sat_at_max", int'(sif.data_output), 20);
    check_eq("sat_at_max_roll", int'(sif.rollover), 1);

    apply(1'b0, 2, 12, 0);
    apply(1'b0, 4, 0, 5);
    check_eq("dec_wrap", int'(wif.data_output), 20);
    check_eq("dec_wrap_roll", int'(wif.rollover), 1);
    apply(1'b0, 4, 0, 0);
    check_eq("dec0", int'(wif.data_output), 20);
    check_eq("dec0_roll", int'(wif.rollover), 0);
    for (int k = 0; k < 3; k++) apply(1'b0, 0, 0, 0);
    check_eq("hold3", int'(wif.data_output), 20);

    apply(1'b0, 2, 12, 0);
    apply(1'b0, 5, 0, 0);
`ifdef BCR_SHIFT_EN
    check_eq("shl", int'(wif.data_output), 20);
    apply(1'b0, 6, 0, 0);
    check_eq("shr", int'(wif.data_output), 10);
`else
    check_eq("shl_hold", int'(wif.data_output), 12);
    apply(1'b0, 6, 0, 0);
    check_eq("shr_hold", int'(wif.data_output), 12);
`endif

    apply(1'b0, 2, 19, 0);
    apply(1'b0, 3, 0, 255);
    check_eq("inc255", int'(wif.data_output), 10);
    check_eq("inc255_roll", int'(wif.rollover), 1);
    apply(1'b1, 3, 0, 255);
    check_eq("rst_mid", int'(wif.data_output), 10);
    check_eq("rst_mid_roll", int'(wif.rollover), 0);

    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      c   = $urandom_range(0, 7);
      din = $urandom_range(0, 255);
      stp = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 255);
      apply(rst, c, din, stp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
